// File: rtl/async_fifo_rd_drain.sv
// Read-side consumer for the 9-bit asynchronous FIFO.
//
// The block watches the FIFO flags, pops words in fixed-length bursts (or
// continuously while a flush is requested) and buffers them in a 2-entry
// skid buffer that feeds a valid/ready output port.
//
// Ports:
//   rclk, rrst             read-domain clock, async active-low reset
//   enable, flush          pop permission, drain-until-empty request
//   rEmpty, rHalf_empty    FIFO flags
//   rData                  FIFO head word (show-ahead)
//   rinc                   pop strobe to the FIFO (combinational)
//   out_data, out_valid,
//   out_ready              downstream valid/ready port
//   state                  current FSM state
//   rd_count               total words popped since reset (wraps)
//   burst_done             one-cycle pulse after the last pop of a burst
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | disabled, never pops
// ARM   | enabled, waiting for a flush request or the burst threshold
// BURST | popping until BURST_LEN words have been taken
// FLUSH | popping until the FIFO is empty or flush is released

module async_fifo_rd_drain #(
   parameter int DSIZE     = 9,
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 16
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             enable,
   input  logic             flush,
   input  logic             rEmpty,
   input  logic             rHalf_empty,
   input  logic [DSIZE-1:0] rData,
   output logic             rinc,
   output logic [DSIZE-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] rd_count,
   output logic             burst_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_BURST = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t           cur_state;
   state_t           nxt_state;
   logic [7:0]       burst_cnt;
   logic [DSIZE-1:0] skid [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       occ;
   logic             space;
   logic             pop;
   logic             load_burst;
   logic             last_pop;

   assign out_valid = (occ != 2'd0);
   assign out_data  = skid[rd_ptr];
   assign pop       = out_valid & out_ready;
   // A slot being handed downstream this cycle can be refilled at the same edge.
   assign space     = (occ != 2'd2) | pop;
   assign state     = cur_state;

   always_comb begin
      nxt_state  = cur_state;
      load_burst = 1'b0;
      rinc       = enable & ~rEmpty & space &
                   ((cur_state == S_BURST) | (cur_state == S_FLUSH));
      last_pop   = (cur_state == S_BURST) & rinc & (burst_cnt == 8'd1);
      case (cur_state)
         S_IDLE: begin
            if (enable) nxt_state = S_ARM;
         end
         S_ARM: begin
            if (!enable) begin
               nxt_state = S_IDLE;
            end else if (flush) begin
               nxt_state = S_FLUSH;
            end else if (!rHalf_empty) begin
               nxt_state  = S_BURST;
               load_burst = 1'b1;
            end
         end
         S_BURST: begin
            if (!enable)       nxt_state = S_IDLE;
            else if (last_pop) nxt_state = S_ARM;
         end
         S_FLUSH: begin
            if (!enable)                nxt_state = S_IDLE;
            else if (rEmpty || !flush)  nxt_state = S_ARM;
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst) begin
         cur_state  <= S_IDLE;
         burst_cnt  <= 8'd0;
         burst_done <= 1'b0;
         rd_count   <= '0;
      end else begin
         cur_state  <= nxt_state;
         burst_done <= last_pop;
         if (load_burst)
            burst_cnt <= 8'(BURST_LEN);
         else if ((cur_state == S_BURST) && rinc)
            burst_cnt <= burst_cnt - 8'd1;
         if (rinc)
            rd_count <= rd_count + 1'b1;
      end
   end

   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst) begin
         skid[0] <= '0;
         skid[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         occ     <= 2'd0;
      end else begin
         if (rinc) begin
            skid[wr_ptr] <= rData;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({rinc, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Bench for async_fifo_rd_drain. A behavioural 32-deep show-ahead FIFO feeds
// the block; each observed pop pushes the FIFO head into an expected queue,
// and a monitor compares every downstream handshake against that queue.
// A second instance with a 4-bit counter shares all inputs to cover wrap.

module tb_async_fifo_rd_drain;

   logic       rclk = 1'b0;
   logic       rrst;
   logic       enable;
   logic       flush;
   logic       rEmpty;
   logic       rHalf_empty;
   logic [8:0] rData;
   logic       out_ready;

   logic        rinc;
   logic [8:0]  out_data;
   logic        out_valid;
   logic [1:0]  state;
   logic [15:0] rd_count;
   logic        burst_done;

   logic        rinc_b;
   logic [8:0]  out_data_b;
   logic        out_valid_b;
   logic [1:0]  state_b;
   logic [3:0]  rd_count_b;
   logic        burst_done_b;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0]  fifo_q [$];
   logic [8:0]  exp_q  [$];
   logic [8:0]  deliv  [$];
   logic [31:0] model_cnt = 0;
   logic        do_pop = 1'b0;

   always #5 rclk = ~rclk;

   async_fifo_rd_drain #(.DSIZE(9), .BURST_LEN(8), .CNT_W(16)) dut (
      .rclk(rclk), .rrst(rrst), .enable(enable), .flush(flush),
      .rEmpty(rEmpty), .rHalf_empty(rHalf_empty), .rData(rData),
      .rinc(rinc), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .state(state), .rd_count(rd_count),
      .burst_done(burst_done));

   async_fifo_rd_drain #(.DSIZE(9), .BURST_LEN(8), .CNT_W(4)) dut_b (
      .rclk(rclk), .rrst(rrst), .enable(enable), .flush(flush),
      .rEmpty(rEmpty), .rHalf_empty(rHalf_empty), .rData(rData),
      .rinc(rinc_b), .out_data(out_data_b), .out_valid(out_valid_b),
      .out_ready(out_ready), .state(state_b), .rd_count(rd_count_b),
      .burst_done(burst_done_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void upd_flags();
      rEmpty      = (fifo_q.size() == 0);
      rHalf_empty = (fifo_q.size() <= 16);
      rData       = (fifo_q.size() != 0) ? fifo_q[0] : 9'h000;
   endfunction

   function automatic void push_word(input logic [8:0] w);
      fifo_q.push_back(w);
      upd_flags();
   endfunction

   function automatic void clear_fifo();
      fifo_q.delete();
      upd_flags();
   endfunction

   task automatic step();
      @(posedge rclk);
      #2;
   endtask

   // Monitor / scoreboard: samples at the falling edge, retires FIFO pops
   // just after the rising edge so the DUT captures the pre-pop head.
   initial begin
      forever begin
         @(negedge rclk);
         if (!rrst) begin
            exp_q.delete();
            model_cnt = 0;
            do_pop    = 1'b0;
         end else begin
            chk("rinc_while_empty", {31'd0, rinc & rEmpty}, 32'd0);
            chk("rinc_while_disabled", {31'd0, rinc & ~enable}, 32'd0);
            chk("rd_count", {16'd0, rd_count}, {16'd0, model_cnt[15:0]});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("sb_unexpected", {23'd0, out_data}, 32'hffff_ffff);
               end else begin
                  chk("sb_data", {23'd0, out_data}, {23'd0, exp_q.pop_front()});
               end
               deliv.push_back(out_data);
            end
            if (rinc) begin
               exp_q.push_back((fifo_q.size() != 0) ? fifo_q[0] : 9'h000);
               model_cnt = model_cnt + 1;
               do_pop    = 1'b1;
            end
            chk("skid_bound", {31'd0, exp_q.size() > 2}, 32'd0);
         end
         @(posedge rclk);
         #1;
         if (do_pop && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            upd_flags();
         end
         do_pop = 1'b0;
      end
   end

   initial begin
      int rc, first, last, bd, bdi;
      logic [1:0] st [12];

      rrst = 1'b0; enable = 1'b0; flush = 1'b0; out_ready = 1'b1;
      clear_fifo();

      // ---------------- reset / idle ----------------
      for (int i = 0; i < 5; i++) push_word(9'(9'h040 + i));
      step(); step(); step();
      @(negedge rclk);
      chk("rst_state", {30'd0, state}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {23'd0, out_data}, 32'd0);
      chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
      chk("rst_burst_done", {31'd0, burst_done}, 32'd0);
      chk("rst_rinc", {31'd0, rinc}, 32'd0);
      step();
      rrst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge rclk);
         chk("idle_rinc", {31'd0, rinc}, 32'd0);
         chk("idle_state", {30'd0, state}, 32'd0);
         step();
      end
      clear_fifo();

      // ---------------- burst ----------------
      deliv.delete();
      for (int i = 0; i < 20; i++) push_word(9'(9'h100 + i));
      enable = 1'b1;
      rc = 0; first = -1; last = -1; bd = 0; bdi = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge rclk);
         if (rinc) begin rc++; if (first < 0) first = i; last = i; end
         if (burst_done) begin bd++; bdi = i; end
         step();
      end
      chk("burst_pops", rc, 8);
      chk("burst_first", first, 2);
      chk("burst_last", last, 9);
      chk("burst_done_cnt", bd, 1);
      chk("burst_done_idx", bdi, 10);
      chk("burst_state_end", {30'd0, state}, 32'd1);
      chk("burst_rd_count", {16'd0, rd_count}, 32'd8);
      chk("burst_deliv_n", deliv.size(), 8);
      for (int i = 0; i < 8 && i < deliv.size(); i++)
         chk("burst_deliv", {23'd0, deliv[i]}, 32'h100 + i);

      // ---------------- backpressure ----------------
      deliv.delete();
      for (int i = 0; i < 8; i++) push_word(9'(9'h1a0 + i));
      out_ready = 1'b0;
      rc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge rclk);
         if (rinc) rc++;
         step();
      end
      chk("bp_pops", rc, 2);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data", {23'd0, out_data}, 32'h108);
      chk("bp_state", {30'd0, state}, 32'd2);
      out_ready = 1'b1;
      repeat (20) step();
      chk("bp_deliv_n", deliv.size(), 8);
      for (int i = 0; i < 8 && i < deliv.size(); i++)
         chk("bp_deliv", {23'd0, deliv[i]}, 32'h108 + i);
      chk("bp_state_end", {30'd0, state}, 32'd1);

      // ---------------- flush ----------------
      enable = 1'b0;
      step(); step(); step();
      clear_fifo();
      deliv.delete();
      for (int i = 0; i < 3; i++) push_word(9'(9'h0a0 + i));
      enable = 1'b1; flush = 1'b1;
      rc = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge rclk);
         if (rinc) rc++;
         st[i] = state;
         step();
      end
      chk("flush_pops", rc, 3);
      chk("flush_state_drained", {30'd0, st[5]}, 32'd3);
      chk("flush_state_after", {30'd0, st[6]}, 32'd1);
      chk("flush_deliv_n", deliv.size(), 3);
      for (int i = 0; i < 3 && i < deliv.size(); i++)
         chk("flush_deliv", {23'd0, deliv[i]}, 32'h0a0 + i);

      // ---------------- enable drop ----------------
      flush = 1'b0; enable = 1'b0;
      step(); step(); step();
      clear_fifo();
      deliv.delete();
      for (int i = 0; i < 20; i++) push_word(9'(9'h180 + i));
      enable = 1'b1;
      step(); step();
      for (int i = 0; i < 3; i++) begin
         @(negedge rclk);
         chk("drop_pre_rinc", {31'd0, rinc}, 32'd1);
         step();
      end
      enable = 1'b0;
      #1;
      chk("drop_rinc_same_cycle", {31'd0, rinc}, 32'd0);
      step();
      chk("drop_state_idle", {30'd0, state}, 32'd0);
      repeat (6) step();
      chk("drop_deliv_n", deliv.size(), 3);
      for (int i = 0; i < 3 && i < deliv.size(); i++)
         chk("drop_deliv", {23'd0, deliv[i]}, 32'h180 + i);
      deliv.delete();
      enable = 1'b1;
      rc = 0; bd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge rclk);
         if (rinc) rc++;
         if (burst_done) bd++;
         step();
      end
      chk("reenable_pops", rc, 8);
      chk("reenable_done", bd, 1);
      chk("reenable_deliv_n", deliv.size(), 8);
      for (int i = 0; i < 8 && i < deliv.size(); i++)
         chk("reenable_deliv", {23'd0, deliv[i]}, 32'h183 + i);
      chk("total_rd_count", {16'd0, rd_count}, 32'd30);
      chk("total_rd_count_w4", {28'd0, rd_count_b}, 32'd14);

      // ---------------- counter wrap ----------------
      rrst = 1'b0; enable = 1'b0; flush = 1'b0;
      step(); step();
      clear_fifo();
      rrst = 1'b1;
      for (int i = 0; i < 17; i++) push_word(9'(9'h050 + i));
      enable = 1'b1; flush = 1'b1;
      repeat (30) step();
      chk("wrap_rd_count_w4", {28'd0, rd_count_b}, 32'd1);
      chk("wrap_rd_count", {16'd0, rd_count}, 32'd17);
      chk("wrap_fifo_empty", fifo_q.size(), 0);
      flush = 1'b0;

      // ---------------- reset mid-burst ----------------
      for (int i = 0; i < 20; i++) push_word(9'(9'h0c0 + i));
      out_ready = 1'b0;
      repeat (6) step();
      @(negedge rclk);
      chk("mrst_pre_valid", {31'd0, out_valid}, 32'd1);
      step();
      rrst = 1'b0;
      #1;
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_rd_count", {16'd0, rd_count}, 32'd0);
      chk("mrst_state", {30'd0, state}, 32'd0);
      chk("mrst_out_data", {23'd0, out_data}, 32'd0);
      step(); step();
      rrst = 1'b1;

      // ---------------- randomized traffic ----------------
      deliv.delete();
      for (int c = 0; c < 2000; c++) begin
         if (fifo_q.size() < 32 && $urandom_range(0, 99) < 60)
            push_word(9'($urandom_range(0, 511)));
         out_ready = ($urandom_range(0, 99) < 70);
         enable    = ($urandom_range(0, 99) < 97);
         if ($urandom_range(0, 99) < 5) flush = ~flush;
         step();
      end
      enable = 1'b1; flush = 1'b1; out_ready = 1'b1;
      repeat (200) step();
      chk("drain_fifo_empty", fifo_q.size(), 0);
      chk("drain_sb_empty", exp_q.size(), 0);
      chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
